// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and byte-lane enable helper for lsu_mem_master
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // size is funct3[1:0]: 0 byte, 1 halfword, 2 word
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
        return size == 2'd2 ? 4'b1111 : size == 2'd1 ? 4'b0011 << lane : 4'b0001 << lane;
    endfunction
endpackage

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: core request/response and data RAM port bundle.
// master = the LSU (takes req_*, mem_q; drives req_ready, resp_*, mem_*), slave = core/RAM side.
interface lsu_mem_master_if #(parameter int ADDR_WIDTH = 32);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_misaligned;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [3:0]            mem_byteena;
    logic [31:0]           mem_data;
    logic                  mem_wren;
    logic [31:0]           mem_q;

    modport master (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_q,
        output req_ready, resp_valid, resp_rdata, resp_misaligned,
               mem_address, mem_byteena, mem_data, mem_wren
    );
    modport slave (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_q,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned,
               mem_address, mem_byteena, mem_data, mem_wren
    );
endinterface

// File: rtl/load_align.sv
// load_align: shifts RAM word by byte lane and sign/zero-extends per load funct3.
// Ports: mem_q (RAM word), lane (byte offset), funct3 (load type) -> data (extended result).
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_q,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] sh;

    assign sh = mem_q >> {lane, 3'b000};

    always_comb
        data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
               funct3 == F3_BU ? {24'b0, sh[7:0]} :
               funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
               funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-request RV32 load/store initiator driving a synchronous byte-enabled RAM.
// Ports: clock, reset (sync, active-high), bus (lsu_mem_master_if.master: req_*, resp_*, mem_*).
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int RAM_LATENCY = 1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic             clock,
    input  logic             reset,
    lsu_mem_master_if.master bus
);
    localparam int CW = RAM_LATENCY > 1 ? $clog2(RAM_LATENCY) : 1;

    state_t         state, state_n;
    logic [CW-1:0]  cnt;
    logic [2:0]     f3_q;
    logic [1:0]     lane_q;
    logic           store_q;
    logic [1:0]     lane;
    logic           accept;
    logic           bad_f3;
    logic           mis;
    logic           fault;
    logic [31:0]    ext;

    assign lane   = bus.req_addr[1:0];
    assign accept = state == IDLE && bus.req_valid;
    assign bad_f3 = bus.req_store ? bus.req_funct3 >= 3'd3
                                  : bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11;
    assign mis    = (bus.req_funct3[1:0] == 2'b01 && lane[0]) ||
                    (bus.req_funct3[1:0] == 2'b10 && lane != 2'b00);
    assign fault  = bad_f3 || mis;

    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.mem_wren   = state == ISSUE && store_q;

    load_align u_align (
        .mem_q  (bus.mem_q),
        .lane   (lane_q),
        .funct3 (f3_q),
        .data   (ext)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (fault ? RESP : ISSUE) : IDLE;
            ISSUE:   state_n = store_q ? RESP : WAIT;
            WAIT:    state_n = cnt == '0 ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            cnt                 <= '0;
            f3_q                <= '0;
            lane_q              <= '0;
            store_q             <= 1'b0;
            bus.resp_rdata      <= '0;
            bus.resp_misaligned <= 1'b0;
            bus.mem_address     <= '0;
            bus.mem_byteena     <= '0;
            bus.mem_data        <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                bus.resp_misaligned <= fault;
                bus.resp_rdata      <= '0;
                // faults leave the RAM-facing registers untouched
                if (!fault) begin
                    bus.mem_address <= ADDR_WIDTH'(bus.req_addr[31:2]);
                    bus.mem_byteena <= lane_be(bus.req_funct3[1:0], lane);
                    bus.mem_data    <= bus.req_funct3 == F3_W ? bus.req_wdata :
                                       bus.req_funct3 == F3_H ? {2{bus.req_wdata[15:0]}} :
                                                                {4{bus.req_wdata[7:0]}};
                    f3_q            <= bus.req_funct3;
                    lane_q          <= lane;
                    store_q         <= bus.req_store;
                end
            end
            if (state == ISSUE)
                cnt <= CW'(RAM_LATENCY - 1);
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - CW'(1);
            if (state == WAIT && cnt == '0)
                bus.resp_rdata <= ext;
        end
    end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: scoreboard bench for lsu_mem_master at RAM_LATENCY 1 (dut_a) and 2 (dut_b)
module tb_lsu_mem_master;
    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          due;
    } exp_t;

    logic clock = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   wren_cyc_a = -1;
    int   wren_cyc_b = -1;
    bit   mon_on = 1'b0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    logic [31:0] ram_a [16];
    logic [31:0] ram_b [16];
    logic [31:0] qb1;

    lsu_mem_master_if #(.ADDR_WIDTH(32)) a ();
    lsu_mem_master_if #(.ADDR_WIDTH(32)) b ();

    lsu_mem_master #(.RAM_LATENCY(1), .ADDR_WIDTH(32)) dut_a (.clock(clock), .reset(reset_a), .bus(a));
    lsu_mem_master #(.RAM_LATENCY(2), .ADDR_WIDTH(32)) dut_b (.clock(clock), .reset(reset_b), .bus(b));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] bemask(input logic [31:0] w, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? w[8*i +: 8] : 8'h00;
        return r;
    endfunction

    always @(posedge clock) begin
        if (a.mem_wren)
            for (int i = 0; i < 4; i++)
                if (a.mem_byteena[i]) ram_a[a.mem_address[3:0]][8*i +: 8] <= a.mem_data[8*i +: 8];
        a.mem_q <= bemask(ram_a[a.mem_address[3:0]], a.mem_byteena);
    end

    always @(posedge clock) begin
        if (b.mem_wren)
            for (int j = 0; j < 4; j++)
                if (b.mem_byteena[j]) ram_b[b.mem_address[3:0]][8*j +: 8] <= b.mem_data[8*j +: 8];
        qb1     <= bemask(ram_b[b.mem_address[3:0]], b.mem_byteena);
        b.mem_q <= qb1;
    end

    // scoreboard: every response is matched against the oldest expectation
    always @(negedge clock) if (mon_on) begin
        if (a.resp_valid === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL resp_a_unexpected: got resp_valid=1 want none at cycle %0d", cyc);
            end else begin
                ea = qa.pop_front();
                checks += 3;
                if (a.resp_rdata !== ea.rdata) begin errors++; $display("FAIL resp_a_rdata: got %h want %h", a.resp_rdata, ea.rdata); end
                if (a.resp_misaligned !== ea.mis) begin errors++; $display("FAIL resp_a_misaligned: got %b want %b", a.resp_misaligned, ea.mis); end
                if (cyc != ea.due) begin errors++; $display("FAIL resp_a_cycle: got %0d want %0d", cyc, ea.due); end
            end
        end
        if (b.resp_valid === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL resp_b_unexpected: got resp_valid=1 want none at cycle %0d", cyc);
            end else begin
                eb = qb.pop_front();
                checks += 3;
                if (b.resp_rdata !== eb.rdata) begin errors++; $display("FAIL resp_b_rdata: got %h want %h", b.resp_rdata, eb.rdata); end
                if (b.resp_misaligned !== eb.mis) begin errors++; $display("FAIL resp_b_misaligned: got %b want %b", b.resp_misaligned, eb.mis); end
                if (cyc != eb.due) begin errors++; $display("FAIL resp_b_cycle: got %0d want %0d", cyc, eb.due); end
            end
        end
        if (a.mem_wren === 1'b1) begin
            checks++;
            if (cyc != wren_cyc_a) begin errors++; $display("FAIL wren_a_stray: got wren=1 at cycle %0d want only at %0d", cyc, wren_cyc_a); end
        end
        if (b.mem_wren === 1'b1) begin
            checks++;
            if (cyc != wren_cyc_b) begin errors++; $display("FAIL wren_b_stray: got wren=1 at cycle %0d want only at %0d", cyc, wren_cyc_b); end
        end
    end

    // drive one request; c is the cycle number seen just before the accept edge
    task automatic send(input bit sel, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input logic mis, input int lat,
                        output int c);
        exp_t e;
        @(negedge clock);
        c = cyc;
        checks++;
        if ((sel ? b.req_ready : a.req_ready) !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_idle: got %b want 1", sel ? b.req_ready : a.req_ready);
        end
        e.rdata = rd;
        e.mis   = mis;
        e.due   = c + lat;
        if (sel) begin
            b.req_valid = 1'b1; b.req_store = st; b.req_funct3 = f3; b.req_addr = addr; b.req_wdata = wd;
            qb.push_back(e);
            if (st && !mis) wren_cyc_b = c + 1;
        end else begin
            a.req_valid = 1'b1; a.req_store = st; a.req_funct3 = f3; a.req_addr = addr; a.req_wdata = wd;
            qa.push_back(e);
            if (st && !mis) wren_cyc_a = c + 1;
        end
        @(posedge clock);
        #1;
        if (sel) b.req_valid = 1'b0; else a.req_valid = 1'b0;
    endtask

    // returns on the negedge of the response cycle, bounded
    task automatic drain(input bit sel);
        int n = 0;
        while ((sel ? b.resp_valid : a.resp_valid) !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL resp_timeout: got no resp_valid in %0d cycles want one (dut %0d)", n, sel);
            if (sel) qb.delete(); else qa.delete();
        end
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
            checks++;
            if (a.mem_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", a.mem_wren); end
        end
        checks += 9;
        if (a.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", a.req_ready); end
        if (a.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", a.resp_valid); end
        if (a.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h want 0", a.resp_rdata); end
        if (a.resp_misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b want 0", a.resp_misaligned); end
        if (a.mem_address !== 32'h0) begin errors++; $display("FAIL reset_mem_address: got %h want 0", a.mem_address); end
        if (a.mem_byteena !== 4'h0) begin errors++; $display("FAIL reset_byteena: got %b want 0000", a.mem_byteena); end
        if (a.mem_data !== 32'h0) begin errors++; $display("FAIL reset_mem_data: got %h want 0", a.mem_data); end
        if (a.mem_wren !== 1'b0) begin errors++; $display("FAIL reset_mem_wren: got %b want 0", a.mem_wren); end
        if (b.req_ready !== 1'b1) begin errors++; $display("FAIL reset_b_req_ready: got %b want 1", b.req_ready); end
        reset_a = 1'b0;
        reset_b = 1'b0;
        mon_on  = 1'b1;
    endtask

    task automatic test_stores();
        logic [2:0]  f3 [2] = '{3'b010, 3'b000};
        logic [31:0] ad [2] = '{32'h10, 32'h13};
        logic [31:0] wd [2] = '{32'hDEADBEEF, 32'h000000AA};
        logic [3:0]  be [2] = '{4'b1111, 4'b1000};
        logic [31:0] md [2] = '{32'hDEADBEEF, 32'hAAAAAAAA};
        int c;
        for (int i = 0; i < 2; i++) begin
            send(1'b0, 1'b1, f3[i], ad[i], wd[i], 32'h0, 1'b0, 2, c);
            @(negedge clock);
            checks += 5;
            if (a.mem_address !== 32'h4) begin errors++; $display("FAIL store%0d_address: got %h want 4", i, a.mem_address); end
            if (a.mem_byteena !== be[i]) begin errors++; $display("FAIL store%0d_byteena: got %b want %b", i, a.mem_byteena, be[i]); end
            if (a.mem_data !== md[i]) begin errors++; $display("FAIL store%0d_data: got %h want %h", i, a.mem_data, md[i]); end
            if (a.mem_wren !== 1'b1) begin errors++; $display("FAIL store%0d_wren: got %b want 1", i, a.mem_wren); end
            if (a.req_ready !== 1'b0) begin errors++; $display("FAIL store%0d_busy: got req_ready %b want 0", i, a.req_ready); end
            drain(1'b0);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [6] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b001};
        logic [31:0] ad [6] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
        logic [31:0] rd [6] = '{32'hAAADBEEF, 32'hFFFFFFAA, 32'h000000AA, 32'hFFFFAAAD, 32'h0000AAAD, 32'hFFFFBEEF};
        logic [3:0]  be [6] = '{4'b1111, 4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0011};
        int c;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 1'b0, f3[i], ad[i], 32'h0, rd[i], 1'b0, 3, c);
            @(negedge clock);
            checks += 2;
            if (a.mem_byteena !== be[i]) begin errors++; $display("FAIL load%0d_byteena: got %b want %b", i, a.mem_byteena, be[i]); end
            if (a.mem_wren !== 1'b0) begin errors++; $display("FAIL load%0d_wren: got %b want 0", i, a.mem_wren); end
            drain(1'b0);
        end
    endtask

    task automatic test_faults();
        logic        st [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b111};
        logic [31:0] ad [3] = '{32'h11, 32'h13, 32'h10};
        int c;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, st[i], f3[i], ad[i], 32'h12345678, 32'h0, 1'b1, 1, c);
            @(negedge clock);
            checks += 3;
            if (a.mem_address !== 32'h4) begin errors++; $display("FAIL fault%0d_address: got %h want 4", i, a.mem_address); end
            if (a.mem_wren !== 1'b0) begin errors++; $display("FAIL fault%0d_wren: got %b want 0", i, a.mem_wren); end
            if (a.resp_valid !== 1'b1) begin errors++; $display("FAIL fault%0d_resp_cycle1: got %b want 1", i, a.resp_valid); end
            drain(1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        send(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hAAADBEEF, 1'b0, 3, c0);
        drain(1'b0);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000AAAD, 1'b0, 3, c1);
            checks++;
            if (c1 - c0 != 4) begin errors++; $display("FAIL b2b_spacing%0d: got %0d want 4", i, c1 - c0); end
            c0 = c1;
            drain(1'b0);
        end
    endtask

    task automatic test_reset_wait();
        int c;
        send(1'b1, 1'b1, 3'b010, 32'h10, 32'hCAFE1234, 32'h0, 1'b0, 2, c);
        drain(1'b1);
        send(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFE1234, 1'b0, 4, c);
        @(negedge clock);
        @(negedge clock);
        qb.delete();
        reset_b = 1'b1;
        @(negedge clock);
        reset_b = 1'b0;
        checks += 2;
        if (b.req_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready: got %b want 1", b.req_ready); end
        if (b.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_resp: got %b want 0", b.resp_valid); end
        repeat (5) @(negedge clock);
        send(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFE1234, 1'b0, 4, c);
        drain(1'b1);
    endtask

    initial begin
        a.req_valid = 1'b0; a.req_store = 1'b0; a.req_funct3 = 3'b0; a.req_addr = 32'h0; a.req_wdata = 32'h0;
        b.req_valid = 1'b0; b.req_store = 1'b0; b.req_funct3 = 3'b0; b.req_addr = 32'h0; b.req_wdata = 32'h0;
        test_reset();
        test_stores();
        test_loads();
        test_faults();
        test_back_to_back();
        test_reset_wait();
        repeat (3) @(negedge clock);
        checks++;
        if (qa.size() + qb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending want 0", qa.size() + qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator for the shrv32 data path. It takes one RV32 load or store request from the core, with a byte address, funct3 and store data. It drives the word-addressed, byte-enabled, synchronous data RAM port: address, byteena, data, wren in; q out, with q masked by byteena. It returns a single response: sign- or zero-extended load data, store completion, or a misalignment fault.

## Interface
- RAM_LATENCY, 1: cycles from the RAM sampling edge to q valid (≥1).
- ADDR_WIDTH, 32: width of mem_address (word index).

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a transfer occurs when req_valid&&req_ready
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB/SH/SW 000/001/010)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_misaligned  out  1  fault flag, valid with resp_valid
- mem_address  out  ADDR_WIDTH  req_addr[31:2]
- mem_byteena  out  4  lane enables
- mem_data  out  32  lane-replicated store data
- mem_wren  out  1  write strobe
- mem_q  in  32  RAM read data

## Operation
- States: IDLE → ISSUE → WAIT (loads) → RESP → IDLE.
  - Stores skip WAIT.
  - Faults go IDLE → RESP directly and never touch the RAM.
- Fault on accept:
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - load funct3 ∈ {011,110,111};
  - store funct3 ≥ 011.
- lane = req_addr[1:0].
- byteena:
  - B: 4'b0001<<lane
  - H: 4'b0011<<lane
  - W: 4'b1111
- mem_data:
  - B: {4{wdata[7:0]}}
  - H: {2{wdata[15:0]}}
  - W: wdata
- Accept registers mem_address, mem_byteena, mem_data and the captured funct3/lane. These outputs hold their values until the next accept.
- mem_wren = 1 only in ISSUE, and only for stores.
- WAIT:
  - Counter loads RAM_LATENCY−1 on entry and decrements each cycle.
  - At count 0, mem_q is captured into resp_rdata and the state moves to RESP.
- Load extraction from mem_q>>(8·lane):
  - LB: sign-extend bit 7.
  - LBU: zero-extend.
  - LH: sign-extend bit 15.
  - LHU: zero-extend.
  - LW: the full word.
- RESP: resp_valid=1 for exactly one cycle. req_valid is ignored outside IDLE.

## Timing
- Reset values:
  - state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_misaligned 0;
  - mem_address 0, mem_byteena 0, mem_data 0, mem_wren 0;
  - WAIT counter 0.
- Counting from accept edge E0:
  - ISSUE is cycle 1.
  - Load: WAIT spans cycles 2..1+RAM_LATENCY; resp_valid in cycle 2+RAM_LATENCY (cycle 3 at default).
  - Store: resp_valid in cycle 2.
  - Fault: resp_valid in cycle 1.
- Next accept happens no earlier than the cycle after RESP. Throughput is one load per 3+RAM_LATENCY cycles.
- Reset asserted in any state: IDLE and all reset values take effect at that edge.
  - A pending response is dropped; no resp_valid is produced.
  - An ISSUE-cycle write cut by reset may or may not complete in the RAM.

## Structure
- Package lsu_pkg:
  - funct3 localparams (F3_B/H/W/BU/HU);
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - the byteena lane function.
- Sub-module load_align: purely combinational.
  - Inputs: mem_q, lane, funct3.
  - Output: extended 32-bit value.
  - It is instantiated once.
- The top level holds the FSM, the latency counter and the request registers.

## Test plan
- Reset: assert 2 cycles. Expect all outputs at their reset values and req_ready=1; mem_wren stays 0 throughout.
- SW 0x10 / 0xDEADBEEF:
  - cycle 1: mem_address=4, byteena=1111, mem_data=0xDEADBEEF, wren=1;
  - cycle 2: resp_valid=1, rdata=0, misaligned=0.
- SB 0x13 / 0x000000AA: byteena=1000, mem_data=0xAAAAAAAA. Then:
  - LW 0x10 → 0xAAADBEEF in cycle 3;
  - LB 0x13 → 0xFFFFFFAA;
  - LBU 0x13 → 0x000000AA.
- LH 0x12 → 0xFFFFAAAD with byteena=1100; LHU 0x12 → 0x0000AAAD; LH 0x10 → 0xFFFFBEEF.
- Faults: LW 0x11, SH 0x13 and load funct3 111 each give resp_valid in cycle 1 with misaligned=1 and rdata=0. mem_wren is never asserted; mem_address keeps its previous value.
- Reset during WAIT (RAM_LATENCY=2 build): no resp_valid follows, and req_ready=1 the cycle after reset. A following LW 0x10 returns in cycle 4.
